// File: rtl/uart_core_cfg.sv
// Full-duplex UART with elaboration-time frame format (data bits, parity, stop bits).
// Ready/valid transmit handshake; receive side reports parity and framing errors.
module uart_core_cfg #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_uart_rxd,
  input  logic                 i_tx_dv,
  input  logic [DATA_BITS-1:0] i_tx_byte,
  output logic                 o_tx_ready,
  output logic                 o_tx_active,
  output logic                 o_tx_done,
  output logic                 o_uart_txd,
  output logic                 o_rx_dv,
  output logic [DATA_BITS-1:0] o_rx_byte,
  output logic                 o_rx_parity_err,
  output logic                 o_rx_frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_DONE,
                            RX_WAIT_HIGH} rx_state_t;

  // Parity bit that completes the data word to the configured odd/even weight
  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY == 1);
  endfunction

  tx_state_t             tx_state, tx_state_nxt;
  logic [CW-1:0]         tx_clk_cnt, tx_clk_nxt;
  logic [BW-1:0]         tx_bit_cnt, tx_bit_nxt;
  logic [DATA_BITS-1:0]  tx_shift, tx_shift_nxt;
  logic                  tx_par, tx_par_nxt, tx_txd_nxt, tx_done_nxt, tx_bit_end;

  assign o_tx_ready  = (tx_state == TX_IDLE);
  assign o_tx_active = (tx_state != TX_IDLE);

  always_comb begin
    tx_state_nxt = tx_state;
    tx_clk_nxt   = tx_clk_cnt + 1'b1;
    tx_bit_nxt   = tx_bit_cnt;
    tx_shift_nxt = tx_shift;
    tx_par_nxt   = tx_par;
    tx_done_nxt  = 1'b0;
    tx_txd_nxt   = 1'b1;
    tx_bit_end   = (tx_clk_cnt == CNT_LAST);
    case (tx_state)
      TX_IDLE: begin
        tx_clk_nxt = '0;
        if (i_tx_dv) begin
          tx_state_nxt = TX_START;
          tx_shift_nxt = i_tx_byte;
          tx_par_nxt   = par_bit(i_tx_byte);
        end
      end
      TX_START: if (tx_bit_end) begin
        tx_state_nxt = TX_DATA;
        tx_clk_nxt   = '0;
        tx_bit_nxt   = '0;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_clk_nxt   = '0;
        tx_shift_nxt = tx_shift >> 1;
        if (tx_bit_cnt == DATA_LAST) begin
          tx_bit_nxt   = '0;
          tx_state_nxt = (PARITY != 0) ? TX_PARITY : TX_STOP;
        end else begin
          tx_bit_nxt = tx_bit_cnt + 1'b1;
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_state_nxt = TX_STOP;
        tx_clk_nxt   = '0;
        tx_bit_nxt   = '0;
      end
      TX_STOP: if (tx_bit_end) begin
        tx_clk_nxt = '0;
        if (tx_bit_cnt == STOP_LAST) begin
          tx_state_nxt = TX_IDLE;
          tx_bit_nxt   = '0;
          tx_done_nxt  = 1'b1;
        end else begin
          tx_bit_nxt = tx_bit_cnt + 1'b1;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
    // Line level is registered alongside the state it belongs to
    case (tx_state_nxt)
      TX_START:  tx_txd_nxt = 1'b0;
      TX_DATA:   tx_txd_nxt = tx_shift_nxt[0];
      TX_PARITY: tx_txd_nxt = tx_par_nxt;
      default:   tx_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tx_state   <= TX_IDLE;
      tx_clk_cnt <= '0;
      tx_bit_cnt <= '0;
      o_uart_txd <= 1'b1;
      o_tx_done  <= 1'b0;
    end else begin
      tx_state   <= tx_state_nxt;
      tx_clk_cnt <= tx_clk_nxt;
      tx_bit_cnt <= tx_bit_nxt;
      o_uart_txd <= tx_txd_nxt;
      o_tx_done  <= tx_done_nxt;
    end
    tx_shift <= tx_shift_nxt;
    tx_par   <= tx_par_nxt;
  end

  rx_state_t             rx_state, rx_state_nxt;
  logic [CW-1:0]         rx_clk_cnt, rx_clk_nxt;
  logic [BW-1:0]         rx_bit_cnt, rx_bit_nxt;
  logic [DATA_BITS-1:0]  rx_shift, rx_shift_nxt;
  logic                  rx_perr, rx_perr_nxt, rx_ferr, rx_ferr_nxt;
  logic                  rxd_p0, rxd_p1, rx_bit_end;

  assign o_rx_dv = (rx_state == RX_DONE);

  always_comb begin
    rx_state_nxt = rx_state;
    rx_clk_nxt   = rx_clk_cnt + 1'b1;
    rx_bit_nxt   = rx_bit_cnt;
    rx_shift_nxt = rx_shift;
    rx_perr_nxt  = rx_perr;
    rx_ferr_nxt  = rx_ferr;
    rx_bit_end   = (rx_clk_cnt == CNT_LAST);
    case (rx_state)
      RX_IDLE: begin
        rx_clk_nxt = '0;
        if (!rxd_p1) begin
          rx_state_nxt = RX_START;
          rx_perr_nxt  = 1'b0;
          rx_ferr_nxt  = 1'b0;
        end
      end
      RX_START: if (rx_clk_cnt == CNT_HALF) begin
        rx_clk_nxt   = '0;
        rx_bit_nxt   = '0;
        rx_state_nxt = rxd_p1 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_bit_end) begin
        rx_clk_nxt   = '0;
        rx_shift_nxt = {rxd_p1, rx_shift[DATA_BITS-1:1]};
        if (rx_bit_cnt == DATA_LAST) begin
          rx_bit_nxt   = '0;
          rx_state_nxt = (PARITY != 0) ? RX_PARITY : RX_STOP;
        end else begin
          rx_bit_nxt = rx_bit_cnt + 1'b1;
        end
      end
      RX_PARITY: if (rx_bit_end) begin
        rx_clk_nxt   = '0;
        rx_perr_nxt  = rxd_p1 ^ par_bit(rx_shift);
        rx_state_nxt = RX_STOP;
      end
      RX_STOP: if (rx_bit_end) begin
        rx_clk_nxt = '0;
        if (!rxd_p1) rx_ferr_nxt = 1'b1;
        if (rx_bit_cnt == STOP_LAST) begin
          rx_bit_nxt   = '0;
          rx_state_nxt = RX_DONE;
        end else begin
          rx_bit_nxt = rx_bit_cnt + 1'b1;
        end
      end
      RX_DONE: begin
        rx_clk_nxt   = '0;
        rx_state_nxt = rx_ferr ? RX_WAIT_HIGH : RX_IDLE;
      end
      RX_WAIT_HIGH: begin
        rx_clk_nxt = '0;
        if (rxd_p1) rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rxd_p0          <= 1'b1;
      rxd_p1          <= 1'b1;
      rx_state        <= RX_IDLE;
      rx_clk_cnt      <= '0;
      rx_bit_cnt      <= '0;
      rx_perr         <= 1'b0;
      rx_ferr         <= 1'b0;
      o_rx_byte       <= '0;
      o_rx_parity_err <= 1'b0;
      o_rx_frame_err  <= 1'b0;
    end else begin
      // Stage p0/p1: two-flop synchroniser on the asynchronous line
      rxd_p0     <= i_uart_rxd;
      rxd_p1     <= rxd_p0;
      rx_state   <= rx_state_nxt;
      rx_clk_cnt <= rx_clk_nxt;
      rx_bit_cnt <= rx_bit_nxt;
      rx_perr    <= rx_perr_nxt;
      rx_ferr    <= rx_ferr_nxt;
      if (rx_state_nxt == RX_DONE) begin
        o_rx_byte       <= rx_shift_nxt;
        o_rx_parity_err <= (PARITY != 0) && rx_perr_nxt;
        o_rx_frame_err  <= rx_ferr_nxt;
      end
    end
    rx_shift <= rx_shift_nxt;
  end
endmodule

// File: tb/tb_uart_core_cfg.sv
// Bench for uart_core_cfg: three instances (8N1 loopback, 8O2 loopback, 7E1 driven RX)
// checked against a frame-level reference model.
module tb_uart_core_cfg;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_asrt = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  logic       a_tx_dv, a_ready, a_active, a_done, a_txd, a_rx_dv, a_perr, a_ferr;
  logic [7:0] a_tx_byte, a_rx_byte;
  logic       b_tx_dv, b_ready, b_active, b_done, b_txd, b_rx_dv, b_perr, b_ferr;
  logic [7:0] b_tx_byte, b_rx_byte;
  logic       c_rxd, c_tx_dv, c_ready, c_active, c_done, c_txd, c_rx_dv, c_perr, c_ferr;
  logic [6:0] c_tx_byte, c_rx_byte;

  uart_core_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rxd(a_txd), .i_tx_dv(a_tx_dv),
    .i_tx_byte(a_tx_byte), .o_tx_ready(a_ready), .o_tx_active(a_active),
    .o_tx_done(a_done), .o_uart_txd(a_txd), .o_rx_dv(a_rx_dv), .o_rx_byte(a_rx_byte),
    .o_rx_parity_err(a_perr), .o_rx_frame_err(a_ferr));

  uart_core_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rxd(b_txd), .i_tx_dv(b_tx_dv),
    .i_tx_byte(b_tx_byte), .o_tx_ready(b_ready), .o_tx_active(b_active),
    .o_tx_done(b_done), .o_uart_txd(b_txd), .o_rx_dv(b_rx_dv), .o_rx_byte(b_rx_byte),
    .o_rx_parity_err(b_perr), .o_rx_frame_err(b_ferr));

  uart_core_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rxd(c_rxd), .i_tx_dv(c_tx_dv),
    .i_tx_byte(c_tx_byte), .o_tx_ready(c_ready), .o_tx_active(c_active),
    .o_tx_done(c_done), .o_uart_txd(c_txd), .o_rx_dv(c_rx_dv), .o_rx_byte(c_rx_byte),
    .o_rx_parity_err(c_perr), .o_rx_frame_err(c_ferr));

  int a_rx_cnt = 0, a_done_cnt = 0, b_rx_cnt = 0, b_done_cnt = 0, c_rx_cnt = 0;
  always @(negedge clk) begin
    #1;
    if (a_rx_dv) a_rx_cnt++;
    if (a_done)  a_done_cnt++;
    if (b_rx_dv) b_rx_cnt++;
    if (b_done)  b_done_cnt++;
    if (c_rx_dv) c_rx_cnt++;
  end

  logic [6:0] c_exp_byte;
  logic       c_exp_perr, c_exp_ferr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial frame as a bit list (index 0 goes on the line first); unused tail bits read 1
  function automatic logic [15:0] frame_bits(input logic [8:0] d, input int db, input int par);
    logic [15:0] f;
    int k, ones;
    f = '1; f[0] = 1'b0; k = 1; ones = 0;
    for (int i = 0; i < db; i++) begin
      f[k] = d[i]; ones += int'(d[i]); k++;
    end
    if (par == 1) f[k] = (ones % 2 == 0);
    if (par == 2) f[k] = (ones % 2 == 1);
    return f;
  endfunction

  task automatic send_a(input logic [7:0] d, input int poke_cyc, input int rst_cyc);
    logic [15:0] f;
    int n, rx0, dn0;
    logic exp_txd, exp_done, exp_ready;
    f = frame_bits({1'b0, d}, 8, 0);
    n = 10;
    rx0 = a_rx_cnt; dn0 = a_done_cnt;
    a_tx_byte = d; a_tx_dv = 1'b1;
    for (int cyc = 1; cyc <= 16 * n + 25; cyc++) begin
      @(negedge clk);
      if (cyc == 1) a_tx_dv = 1'b0;
      if (cyc == poke_cyc) begin a_tx_dv = 1'b1; a_tx_byte = 8'h12; end
      if (cyc == poke_cyc + 1) begin a_tx_dv = 1'b0; a_tx_byte = d; end
      if (rst_cyc > 0 && cyc == rst_cyc) rst_n = 1'b0;
      if (rst_cyc > 0 && cyc == rst_cyc + 1) rst_n = 1'b1;
      exp_txd   = (cyc <= 16 * n) ? f[(cyc - 1) / CPB] : 1'b1;
      exp_done  = (cyc == 16 * n + 1);
      exp_ready = (cyc > 16 * n);
      if (rst_cyc > 0 && cyc > rst_cyc) begin
        exp_txd = 1'b1; exp_done = 1'b0; exp_ready = 1'b1;
      end
      chk("a_txd", a_txd, exp_txd);
      chk("a_tx_done", a_done, exp_done);
      chk("a_tx_ready", a_ready, exp_ready);
      chk("a_tx_active", a_active, !exp_ready);
      if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
        chk("a_rst_rx_byte", a_rx_byte, 0);
        chk("a_rst_rx_ferr", a_ferr, 0);
        chk("c_rst_rx_byte", c_rx_byte, 0);
      end
    end
    if (rst_cyc > 0) begin
      chk("a_rst_no_rx_dv", a_rx_cnt, rx0);
      chk("a_rst_no_done", a_done_cnt, dn0);
    end else begin
      chk("a_rx_count", a_rx_cnt, rx0 + 1);
      chk("a_done_count", a_done_cnt, dn0 + 1);
      chk("a_rx_byte", a_rx_byte, d);
      chk("a_rx_perr", a_perr, 0);
      chk("a_rx_ferr", a_ferr, 0);
    end
  endtask

  task automatic send_b(input logic [7:0] d, input int par_exp);
    logic [15:0] f;
    int n, rx0, dn0;
    f = frame_bits({1'b0, d}, 8, 1);
    n = 12;
    rx0 = b_rx_cnt; dn0 = b_done_cnt;
    b_tx_byte = d; b_tx_dv = 1'b1;
    for (int cyc = 1; cyc <= 16 * n + 25; cyc++) begin
      @(negedge clk);
      if (cyc == 1) b_tx_dv = 1'b0;
      chk("b_txd", b_txd, (cyc <= 16 * n) ? f[(cyc - 1) / CPB] : 1'b1);
      chk("b_tx_done", b_done, cyc == 16 * n + 1);
      if (par_exp >= 0 && cyc == 1 + 16 * 9 + 8) chk("b_parity_bit", b_txd, par_exp);
    end
    chk("b_rx_count", b_rx_cnt, rx0 + 1);
    chk("b_done_count", b_done_cnt, dn0 + 1);
    chk("b_rx_byte", b_rx_byte, d);
    chk("b_rx_perr", b_perr, 0);
    chk("b_rx_ferr", b_ferr, 0);
  endtask

  task automatic drive_c(input logic [6:0] d, input logic bad_par, input logic bad_stop);
    logic [15:0] f;
    int c0;
    f = frame_bits({2'b00, d}, 7, 2);
    f[8] = f[8] ^ bad_par;
    f[9] = !bad_stop;
    c0 = c_rx_cnt;
    for (int i = 0; i < 10; i++) begin
      c_rxd = f[i];
      repeat (CPB) @(negedge clk);
    end
    c_rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    c_exp_byte = d; c_exp_perr = bad_par; c_exp_ferr = bad_stop;
    chk("c_rx_count", c_rx_cnt, c0 + 1);
    chk("c_rx_byte", c_rx_byte, c_exp_byte);
    chk("c_rx_perr", c_perr, c_exp_perr);
    chk("c_rx_ferr", c_ferr, c_exp_ferr);
  endtask

  int c_base;

  initial begin
    rst_n = 1'b0; c_rxd = 1'b1;
    a_tx_dv = 1'b0; a_tx_byte = '0;
    b_tx_dv = 1'b0; b_tx_byte = '0;
    c_tx_dv = 1'b0; c_tx_byte = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_a_txd", a_txd, 1);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_a_active", a_active, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_rx_dv", a_rx_dv, 0);
    chk("rst_a_rx_byte", a_rx_byte, 0);
    chk("rst_a_perr", a_perr, 0);
    chk("rst_a_ferr", a_ferr, 0);
    chk("rst_b_txd", b_txd, 1);
    chk("rst_c_rx_byte", c_rx_byte, 0);
    chk("rst_c_ferr", c_ferr, 0);
    repeat (4) @(negedge clk);

    // 8N1 0xAB with a 0x12 request while busy, then random bytes
    send_a(8'hAB, 40, 0);
    for (int i = 0; i < 3; i++) send_a(8'($urandom), 0, 0);

    // 8O2 loopback: 0x3F carries parity 1
    send_b(8'h3F, 1);
    for (int i = 0; i < 3; i++) send_b(8'($urandom), -1);

    // 7E1 received frames: parity error case, then random error mixes
    drive_c(7'h55, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive_c(7'($urandom), 1'($urandom), 1'($urandom));

    // Break: 30 bit times low gives one frame-error delivery only
    c_base = c_rx_cnt;
    c_rxd = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    chk("brk_rx_count", c_rx_cnt, c_base + 1);
    chk("brk_rx_byte", c_rx_byte, 0);
    chk("brk_rx_ferr", c_ferr, 1);
    chk("brk_rx_perr", c_perr, 0);
    c_rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("brk_idle_count", c_rx_cnt, c_base + 1);
    drive_c(7'($urandom), 1'b0, 1'b0);

    // Glitch shorter than half a bit is rejected and leaves held outputs alone
    c_base = c_rx_cnt;
    c_rxd = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    c_rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_count", c_rx_cnt, c_base);
    chk("glitch_byte", c_rx_byte, c_exp_byte);
    chk("glitch_ferr", c_ferr, c_exp_ferr);

    // Reset at bit 4 of a loopback frame, then full recovery
    send_a(8'hC3, 0, 0);
    send_a(8'($urandom), 0, 1 + 4 * CPB + 5);
    chk("rst_c_perr", c_perr, 0);
    send_a(8'($urandom), 0, 0);
    drive_c(7'($urandom), 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
